// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter.
// Define UART_ARB_FRAME_EN to hold the grant across multi-byte messages.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win;
  logic [IW-1:0]      nxt;
  logic [7:0]         cnt;
  logic [NUM_REQ-1:0] elig;
  logic               any;
  logic [IW:0]        j;

`ifdef UART_ARB_FRAME_EN
  logic lock;

  always_comb begin
    elig = req_valid;
    if (lock)
      elig = req_valid & (NUM_REQ'(1) << grant_id);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig = req_valid;
`endif

  assign any = |elig;
  assign nxt = (grant_id == IW'(NUM_REQ - 1)) ?
               '0 : grant_id + 1'b1;

  // scan downward so the lowest offset from ptr wins
  always_comb begin
    win = '0;
    j   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(NUM_REQ))
        j = j - (IW+1)'(NUM_REQ);
      if (elig[j[IW-1:0]])
        win = j[IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
`ifdef UART_ARB_FRAME_EN
      lock        <= 1'b0;
`endif
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any && !tx_busy) begin
            tx_data   <= req_data[8*win +: 8];
            grant_id  <= win;
            req_ready <= NUM_REQ'(1) << win;
            tx_start  <= 1'b1;
            cnt       <= '0;
            state     <= WAIT_ACK;
`ifdef UART_ARB_FRAME_EN
            lock      <= ~req_last[win];
`endif
          end
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            ptr         <= nxt;
`ifdef UART_ARB_FRAME_EN
            lock        <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
`ifdef UART_ARB_FRAME_EN
            ptr   <= lock ? grant_id : nxt;
`else
            ptr   <= nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter between `NUM_REQ` requesters. It accepts a byte from one requester at a time and issues a one-cycle start pulse with the byte to the transmitter. It then tracks the transmitter's busy handshake until the frame completes. It sits between client logic (command responders, status reporters) and the UART TX datapath.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ACK_TIMEOUT`, 16: clock cycles to wait for `tx_busy` to rise after a start pulse, 1..255.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `req_valid`, input, `NUM_REQ`: requester i has a byte pending.
- `req_data`, input, `8*NUM_REQ`: byte of requester i in bits `[8*i+7:8*i]`.
- `req_last`, input, `NUM_REQ`: byte of requester i ends its message (used only with `UART_ARB_FRAME_EN`).
- `req_ready`, output, `NUM_REQ`: one-cycle accept pulse to requester i.
- `tx_start`, output, 1: one-cycle start pulse to the transmitter.
- `tx_data`, output, 8: byte to transmit, stable from `tx_start` until the next accept.
- `tx_busy`, input, 1: transmitter is sending a frame.
- `grant_id`, output, `$clog2(NUM_REQ)`: index of the last granted requester.
- `timeout_err`, output, 1: one-cycle pulse when the busy acknowledge is missed.

## Operation

- The state machine has three states: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Grant happens when any eligible `req_valid` is set and `tx_busy`=0.
  - Winner is the first set bit scanning from `ptr` upward, wrapping modulo `NUM_REQ`.
  - On the next edge: `tx_data`<=winner's byte, `grant_id`<=winner, `req_ready[winner]`<=1, `tx_start`<=1, timeout counter<=0, state moves to WAIT_ACK.
- WAIT_ACK:
  - `tx_busy`=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `ACK_TIMEOUT`, `timeout_err` pulses, the state returns to IDLE and `ptr` advances. The byte is dropped and not retried.
- WAIT_DONE: `tx_busy`=0 moves to IDLE, with `ptr`<=(`grant_id`+1) mod `NUM_REQ`.
- `req_ready` and `tx_start` are high for exactly one cycle per grant, always together. At most one `req_ready` bit is set at any time.
- Requesters must hold `req_valid` and data stable until `req_ready`. Dropping `req_valid` before grant is legal and simply withdraws the request.
- If `tx_busy` is already 1 while in IDLE (transmitter in use externally), no grant is issued until it falls.
- Eligible means all requesters, unless a frame lock is active (see Configuration).

## Timing

- Reset values:
  - `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `grant_id`=0, `timeout_err`=0.
  - `ptr`=0, lock cleared, state IDLE.
- Reset takes priority over every other event, including mid-frame. After reset the arbiter ignores `tx_busy` history and restarts from IDLE.
- Latency: a request seen in IDLE with `tx_busy`=0 at edge N drives `req_ready`/`tx_start` high during cycle N+1.
- Minimum spacing between grants: the start pulse, then at least one cycle of `tx_busy`=1, then one IDLE cycle with `tx_busy`=0.
- Timeout: `timeout_err` is high in cycle N+1+`ACK_TIMEOUT` if `tx_busy` never rose. IDLE is re-entered in the same cycle.
- `tx_busy` rising in the same cycle the counter reaches `ACK_TIMEOUT`: the acknowledge wins, with no error.
- `ptr` wraps from `NUM_REQ`-1 to 0.

## Configuration

- Macro: `UART_ARB_FRAME_EN`.
- Defined:
  - Accepting a byte with `req_last[grant_id]`=0 sets a lock. Only `grant_id` is eligible and `ptr` stays on it.
  - Accepting a byte with `req_last`=1 clears the lock and `ptr` advances normally.
  - A timeout clears the lock.
  - While locked, other requesters wait even if the locked requester's `req_valid` is low.
- Undefined: `req_last` is ignored, there is no lock, and arbitration is per byte.

## Test plan

- Reset, then `req_valid`=4'b0001 with data 8'h41 and the transmitter model acknowledging: `req_ready`=4'b0001 and `tx_start` one cycle later, `tx_data`=8'h41, `grant_id`=0.
- All four valid with bytes 8'hA0..8'hA3, each held until accepted: grant order 0,1,2,3, then 0 again; each `tx_start` occurs only after `tx_busy` fell.
- Transmitter never raises `tx_busy`: `timeout_err` pulses exactly `ACK_TIMEOUT`+1 cycles after the grant edge; the next pending requester is granted afterward.
- `rst` asserted while in WAIT_DONE with `tx_busy`=1: all outputs return to reset values next cycle; no grant while `tx_busy` stays high.
- With `UART_ARB_FRAME_EN`, requester 2 sends 3 bytes (`req_last` 0,0,1) while requester 0 is valid: requester 0 is served only after the third byte; without the macro, grants alternate 2,0,2…
